// File: rtl/sprite_pixel_pipe.sv
// sprite_pixel_pipe
//   Turns a per-pixel sprite request (sprite number plus screen-pixel offset
//   inside the sprite's on-screen box) into a sprite-sheet RAM read. It then
//   maps the returned palette index to RGB888 and a transparency flag.
//   Sprite descriptors (base, width, height) and the palette can be loaded at
//   run time. Sheet pixels are scaled up by 2**SCALE_LOG2 on both axes, and
//   optional horizontal mirroring is supported.
//
// Handshake: there is no ready and no backpressure. Every cycle with
//   req_valid = 1 is one accepted pixel. Exactly 3 cycles later out_valid is
//   high for one cycle, carrying that pixel. Pixels come out in request order.
//
// Ports
//   Clk, Reset                  clock (rising edge), synchronous active-high reset
//   req_valid, sprite_num,
//   rel_x, rel_y, flip_x        pixel request
//   desc_we, desc_addr,
//   desc_base, desc_w, desc_h   descriptor table write port
//   pal_we, pal_waddr, pal_wdata palette write port
//   ram_addr, ram_rd_en         registered read request to the sprite frame RAM
//   ram_data                    synchronous RAM data, valid one cycle after ram_addr
//   out_valid, R, G, B,
//   transparent, oob            pixel result
module sprite_pixel_pipe #(
    parameter int NUM_SPRITES     = 32,
    parameter int NUM_W           = $clog2(NUM_SPRITES),
    parameter int ADDR_W          = 20,
    parameter int IDX_W           = 4,
    parameter int SHEET_W         = 46,
    parameter int SCALE_LOG2      = 3,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic [NUM_W-1:0]  sprite_num,
    input  logic [9:0]        rel_x,
    input  logic [9:0]        rel_y,
    input  logic              flip_x,
    input  logic              desc_we,
    input  logic [NUM_W-1:0]  desc_addr,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [7:0]        desc_w,
    input  logic [7:0]        desc_h,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [23:0]       pal_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [IDX_W-1:0]  ram_data,
    output logic              out_valid,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              transparent,
    output logic              oob
);

    localparam int PAL_DEPTH = 2 ** IDX_W;

    logic [ADDR_W-1:0] desc_base_tab [NUM_SPRITES];
    logic [7:0]        desc_w_tab    [NUM_SPRITES];
    logic [7:0]        desc_h_tab    [NUM_SPRITES];
    logic [23:0]       pal           [PAL_DEPTH];

    // Pipeline flags that travel alongside the RAM access
    logic v1, oob1, v2, oob2;

    function automatic logic [23:0] pal_default(input int i);
        case (i)
            0:       return 24'h800080;
            1:       return 24'hFFFDFB;
            2:       return 24'hB53121;
            3:       return 24'hF83800;
            4:       return 24'hE18300;
            5:       return 24'h1D7B01;
            6:       return 24'hAC7C00;
            7:       return 24'hD4E7C7;
            8:       return 24'h057987;
            default: return 24'h000000;
        endcase
    endfunction

    // Stage 0: address generation. The descriptor read is combinational from
    // registered tables, so a same-cycle descriptor write is not yet visible here.
    logic [9:0]        sx, sy, w_ext, h_ext, col;
    logic              oob0;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        w_ext = {2'b00, desc_w_tab[sprite_num]};
        h_ext = {2'b00, desc_h_tab[sprite_num]};
        sx    = rel_x >> SCALE_LOG2;
        sy    = rel_y >> SCALE_LOG2;
        oob0  = (sx >= w_ext) || (sy >= h_ext);
        // Only used when sx < w, so w - 1 - sx cannot underflow on a real read
        col   = flip_x ? (w_ext - 10'd1 - sx) : sx;
        addr_next = desc_base_tab[sprite_num]
                  + ADDR_W'(sy) * ADDR_W'(SHEET_W)
                  + ADDR_W'(col);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                desc_base_tab[i] <= '0;
                desc_w_tab[i]    <= '0;
                desc_h_tab[i]    <= '0;
            end
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal[i] <= pal_default(i);
            end
            v1          <= 1'b0;
            oob1        <= 1'b0;
            v2          <= 1'b0;
            oob2        <= 1'b0;
            ram_addr    <= '0;
            ram_rd_en   <= 1'b0;
            out_valid   <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            transparent <= 1'b0;
            oob         <= 1'b0;
        end else begin
            if (desc_we) begin
                desc_base_tab[desc_addr] <= desc_base;
                desc_w_tab[desc_addr]    <= desc_w;
                desc_h_tab[desc_addr]    <= desc_h;
            end
            if (pal_we) begin
                pal[pal_waddr] <= pal_wdata;
            end

            // Stage 0 -> 1: issue the RAM read
            v1        <= req_valid;
            oob1      <= oob0;
            ram_rd_en <= req_valid & ~oob0;
            if (req_valid) begin
                ram_addr <= addr_next;
            end

            // Stage 1 -> 2: RAM access in flight
            v2   <= v1;
            oob2 <= oob1;

            // Stage 2 -> outputs: palette lookup reads the pre-write colour
            out_valid <= v2;
            if (v2) begin
                if (oob2) begin
                    {R, G, B}   <= 24'h000000;
                    transparent <= 1'b1;
                    oob         <= 1'b1;
                end else begin
                    {R, G, B}   <= pal[ram_data];
                    transparent <= (ram_data == IDX_W'(TRANSPARENT_IDX));
                    oob         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
module tb_sprite_pixel_pipe;

    localparam int NUM_W  = 5;
    localparam int ADDR_W = 20;
    localparam int IDX_W  = 4;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic Reset;

    logic              req_valid;
    logic [NUM_W-1:0]  sprite_num;
    logic [9:0]        rel_x, rel_y;
    logic              flip_x;
    logic              desc_we;
    logic [NUM_W-1:0]  desc_addr;
    logic [ADDR_W-1:0] desc_base;
    logic [7:0]        desc_w, desc_h;
    logic              pal_we;
    logic [IDX_W-1:0]  pal_waddr;
    logic [23:0]       pal_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [IDX_W-1:0]  ram_data;
    logic              out_valid;
    logic [7:0]        R, G, B;
    logic              transparent, oob;

    sprite_pixel_pipe dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .sprite_num(sprite_num),
        .rel_x(rel_x), .rel_y(rel_y), .flip_x(flip_x),
        .desc_we(desc_we), .desc_addr(desc_addr), .desc_base(desc_base),
        .desc_w(desc_w), .desc_h(desc_h),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
        .out_valid(out_valid), .R(R), .G(G), .B(B),
        .transparent(transparent), .oob(oob)
    );

    // Synchronous frame RAM model (low 1024 words are enough here)
    logic [IDX_W-1:0] ram_mem [1024];
    always @(posedge Clk) begin
        if (ram_rd_en) ram_data <= ram_mem[ram_addr[9:0]];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [25:0] exp_q[$];   // {oob, transparent, RGB}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [25:0] px(input logic o, input logic t, input logic [23:0] rgb);
        return {o, t, rgb};
    endfunction

    // Monitor: pops one expectation per out_valid cycle
    logic [25:0] mon_got, mon_want;
    always @(negedge Clk) begin
        if (out_valid === 1'b1) begin
            mon_got = {oob, transparent, R, G, B};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got %h want none", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                check("pixel", 32'(mon_got), 32'(mon_want));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_desc(input logic [4:0] num, input logic [19:0] base,
                              input logic [7:0] w, input logic [7:0] h);
        @(negedge Clk);
        desc_we = 1'b1; desc_addr = num; desc_base = base; desc_w = w; desc_h = h;
        @(negedge Clk);
        desc_we = 1'b0;
    endtask

    task automatic set_req(input logic [4:0] num, input int rx, input int ry, input logic flip);
        req_valid = 1'b1; sprite_num = num;
        rel_x = 10'(rx); rel_y = 10'(ry); flip_x = flip;
    endtask

    // Request, then check the RAM read it produced one cycle later
    task automatic req_addr(input logic [4:0] num, input int rx, input int ry, input logic flip,
                            input logic [25:0] exp_px, input int exp_addr, input logic exp_rd);
        @(negedge Clk);
        set_req(num, rx, ry, flip);
        exp_q.push_back(exp_px);
        @(negedge Clk);
        req_valid = 1'b0;
        check("ram_rd_en", 32'(ram_rd_en), 32'(exp_rd));
        if (exp_rd) check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    endtask

    task automatic drain();
        repeat (5) @(negedge Clk);
    endtask

    int          stream_addr [8] = '{230, 231, 232, 276, 277, 278, 322, 323};
    logic [23:0] stream_rgb  [8] = '{24'hFFFDFB, 24'hB53121, 24'hF83800, 24'hE18300,
                                     24'h1D7B01, 24'hAC7C00, 24'hD4E7C7, 24'h057987};

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
        ram_data = '0;
        Reset = 1'b1;
        req_valid = 1'b0; sprite_num = '0; rel_x = '0; rel_y = '0; flip_x = 1'b0;
        desc_we = 1'b0; desc_addr = '0; desc_base = '0; desc_w = '0; desc_h = '0;
        pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;

        repeat (3) @(negedge Clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_ram_rd_en", 32'(ram_rd_en), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_rgb", 32'({R, G, B}), 0);
        check("rst_transparent", 32'(transparent), 0);
        check("rst_oob", 32'(oob), 0);
        Reset = 1'b0;

        // Cleared descriptor: everything is out of the box
        req_addr(1, 0, 0, 0, px(1, 1, 24'h0), 0, 0);

        // Basic fetch
        ram_mem[0] = 4'd3;
        write_desc(1, 20'd0, 8'd3, 8'd4);
        req_addr(1, 0, 0, 0, px(0, 0, 24'hF83800), 0, 1);

        // Scaled address, with and without mirroring
        ram_mem[278] = 4'd2;
        ram_mem[276] = 4'd4;
        ram_mem[277] = 4'd0;
        write_desc(1, 20'd230, 8'd3, 8'd4);
        req_addr(1, 17, 9, 0, px(0, 0, 24'hB53121), 278, 1);
        req_addr(1, 17, 9, 1, px(0, 0, 24'hE18300), 276, 1);

        // Outside the box on x and on y
        req_addr(1, 24, 0, 0, px(1, 1, 24'h0), 0, 0);
        req_addr(1, 0, 32, 0, px(1, 1, 24'h0), 0, 0);

        // Transparent index, palette write colliding with its lookup
        req_addr(1, 8, 8, 0, px(0, 1, 24'h800080), 277, 1);
        @(negedge Clk);
        pal_we = 1'b1; pal_waddr = 4'd0; pal_wdata = 24'h123456;
        @(negedge Clk);
        pal_we = 1'b0;
        req_addr(1, 8, 8, 0, px(0, 1, 24'h123456), 277, 1);
        drain();

        // Eight back-to-back requests
        for (int k = 0; k < 8; k++) ram_mem[stream_addr[k]] = 4'(k + 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (k < 8) begin
                set_req(1, (k % 3) * 8, (k / 3) * 8, 0);
                exp_q.push_back(px(0, 0, stream_rgb[k]));
            end else begin
                req_valid = 1'b0;
            end
            if (k >= 3 && k < 11) check("stream_valid", 32'(out_valid), 1);
            if (k == 11) check("stream_end", 32'(out_valid), 0);
        end
        drain();

        // Reset one cycle after a request drops it
        @(negedge Clk);
        set_req(1, 0, 0, 0);
        @(negedge Clk);
        req_valid = 1'b0;
        Reset = 1'b1;
        check("midrst_valid", 32'(out_valid), 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("midrst_valid", 32'(out_valid), 0);
        end

        // Descriptor write in the same cycle as a request to that entry
        ram_mem[147] = 4'd5;
        ram_mem[547] = 4'd7;
        ram_mem[500] = 4'd0;
        write_desc(2, 20'd100, 8'd4, 8'd4);
        @(negedge Clk);
        set_req(2, 8, 8, 0);
        exp_q.push_back(px(0, 0, 24'h1D7B01));
        desc_we = 1'b1; desc_addr = 5'd2; desc_base = 20'd500; desc_w = 8'd4; desc_h = 8'd4;
        @(negedge Clk);
        req_valid = 1'b0;
        desc_we = 1'b0;
        check("desc_old_addr", 32'(ram_addr), 147);
        req_addr(2, 8, 8, 0, px(0, 0, 24'hD4E7C7), 547, 1);
        // Palette entry 0 is back to its default after reset
        req_addr(2, 0, 0, 0, px(0, 1, 24'h800080), 500, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
